alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Byte-serial sequencer that drives the ALU from a UART receiver/transmitter pair. It collects operand A, operand B and the opcode as three consecutive received bytes, then presents them to the ALU and holds them stable. It samples the 9-bit ALU result and returns it as two transmitted bytes. It sits between the UART RX/TX blocks and the combinational ALU datapath in the top level.

## Interface
- NB_DATA, 8: operand width; also the UART byte width.
- NB_OPS, 6: opcode width.
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done is high.
- i_rx_done  in  1  one-cycle pulse, one per received byte.
- i_tx_done  in  1  one-cycle pulse when the transmitter has finished the current byte.
- i_alu_res  in  NB_DATA+1  ALU result {carry, res}, combinational from o_data_a/o_data_b/o_ops.
- o_data_a  out  NB_DATA  operand A to the ALU.
- o_data_b  out  NB_DATA  operand B to the ALU.
- o_ops  out  NB_OPS  opcode to the ALU.
- o_tx_data  out  NB_DATA  byte to transmit.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  out  1  high from opcode capture until the second tx_done.
- o_op_err  out  1  one-cycle pulse when a received opcode byte is rejected.
- o_overrun  out  1  sticky flag: an RX byte was dropped while busy; cleared only by reset.

## Operation
- States, in order: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- WAIT_A / WAIT_B: on i_rx_done, register the byte into o_data_a / o_data_b and advance.
- WAIT_OP, on i_rx_done:
  - If byte[7:NB_OPS] is nonzero, pulse o_op_err, leave o_ops unchanged and go to WAIT_A.
  - Otherwise register byte[NB_OPS-1:0] into o_ops and go to EXEC.
- Opcode values are not checked beyond the width test. Unknown 6-bit codes are passed through; the ALU applies its own default.
- EXEC: capture i_alu_res into an internal result register, then go to SEND_LO.
- SEND_LO: o_tx_data = result[NB_DATA-1:0], pulse o_tx_start, go to WAIT_LO.
- WAIT_LO: hold o_tx_data; on i_tx_done go to SEND_HI.
- SEND_HI: o_tx_data = {(NB_DATA-1)'b0, result[NB_DATA]}, pulse o_tx_start, go to WAIT_HI.
- WAIT_HI: on i_tx_done go to WAIT_A.
- o_data_a, o_data_b and o_ops keep their values until overwritten by a new byte.
- i_rx_done while in EXEC, SEND_* or WAIT_*: the byte is dropped and o_overrun is set. No state effect.
- i_rx_done and i_tx_done in the same cycle in WAIT_LO/WAIT_HI: the tx_done transition is taken and the RX byte is dropped (overrun set).
- i_tx_done outside WAIT_LO/WAIT_HI: ignored.
- No timeout. The block waits indefinitely for i_rx_done or i_tx_done.

## Timing
- Reset (async assert, sync release): state WAIT_A; every output and the result register are 0. Applies in any state, including mid-transmission. A pending tx byte is abandoned; no o_tx_start follows reset.
- Byte to register: an operand or opcode appears on its output the cycle after i_rx_done.
- ALU settle time: i_alu_res is sampled in EXEC, one full cycle after o_ops updates.
- First o_tx_start: 2 cycles after the opcode's i_rx_done (EXEC, then SEND_LO).
- Second o_tx_start: 1 cycle after the first i_tx_done.
- o_busy: rises the cycle after the opcode is accepted (state EXEC); falls the cycle after the second i_tx_done.
- o_tx_start is exactly 1 cycle wide. o_tx_data is valid from that cycle until the matching i_tx_done.

## Structure
- Package alu_ctrl_pkg holds:
  - the state enum (3 bits);
  - opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111;
  - default NB_DATA/NB_OPS values.
- No sub-module: the FSM and capture registers live in one module. The ALU is instantiated beside it at the top level.

## Test plan
- RX 0x05, 0x03, 0x20 -> o_ops=6'h20 on the next cycle; TX bytes 0x08 then 0x00; o_busy low after the second tx_done.
- RX 0xFF, 0x01, 0x20 (unsigned add carry) -> TX 0x00 then 0x01.
- RX 0x03, 0x05, 0x22 (SUB) -> TX 0xFE then 0x00. Then RX 0x80, 0x00, 0x03 (SRA) -> TX 0xC0 then 0x00.
- RX 0x01, 0x02, 0xC0 -> o_op_err pulses 1 cycle, no o_tx_start. The next RX 0x07 lands in o_data_a.
- Extra RX byte during WAIT_LO, coincident with i_tx_done -> o_overrun=1, SEND_HI still issued, operands unchanged.
- Assert i_rst_n=0 in WAIT_LO -> all outputs 0 immediately, no further o_tx_start. The next three RX bytes complete a normal operation.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the UART-driven ALU sequencer.
package alu_ctrl_pkg;

    localparam int unsigned NbDataDefault = 8;
    localparam int unsigned NbOpsDefault  = 6;

    // Sequencer states, in the order a normal transaction visits them.
    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StSendLo,
        StWaitLo,
        StSendHi,
        StWaitHi
    } state_e;

    // ALU opcodes (MIPS-style function codes).
    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpSra = 6'b000011;
    localparam logic [5:0] OpSrl = 6'b000010;
    localparam logic [5:0] OpNor = 6'b100111;

endpackage

// File: rtl/alu_uart_ctrl.sv
// Byte-serial sequencer: collects A, B and opcode from the UART receiver,
// holds them on the ALU inputs, and returns the 9-bit result as two bytes.
module alu_uart_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA = NbDataDefault,
    parameter int unsigned NB_OPS  = NbOpsDefault
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA:0]   i_alu_res,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OPS-1:0]  o_ops,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_op_err,
    output logic               o_overrun
);

    state_e             state_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OPS-1:0]  ops_q;
    logic [NB_DATA:0]   res_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               op_err_q;
    logic               overrun_q;
    logic               rx_blocked;

    // RX bytes are only accepted while collecting operands/opcode.
    assign rx_blocked = (state_q != StWaitA) && (state_q != StWaitB) && (state_q != StWaitOp);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StWaitA;
            data_a_q   <= '0;
            data_b_q   <= '0;
            ops_q      <= '0;
            res_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_err_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            op_err_q   <= 1'b0;
            if (i_rx_done && rx_blocked) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StWaitA: begin
                    if (i_rx_done) begin
                        data_a_q <= i_rx_data;
                        state_q  <= StWaitB;
                    end
                end
                StWaitB: begin
                    if (i_rx_done) begin
                        data_b_q <= i_rx_data;
                        state_q  <= StWaitOp;
                    end
                end
                StWaitOp: begin
                    if (i_rx_done) begin
                        if (i_rx_data[NB_DATA-1:NB_OPS] != '0) begin
                            op_err_q <= 1'b1;
                            state_q  <= StWaitA;
                        end else begin
                            ops_q   <= i_rx_data[NB_OPS-1:0];
                            busy_q  <= 1'b1;
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    // ALU inputs have been stable for a full cycle; the low byte
                    // is loaded now so it is on o_tx_data together with the start.
                    res_q      <= i_alu_res;
                    tx_data_q  <= i_alu_res[NB_DATA-1:0];
                    tx_start_q <= 1'b1;
                    state_q    <= StSendLo;
                end
                StSendLo: state_q <= StWaitLo;
                StWaitLo: begin
                    if (i_tx_done) begin
                        tx_data_q  <= {{(NB_DATA-1){1'b0}}, res_q[NB_DATA]};
                        tx_start_q <= 1'b1;
                        state_q    <= StSendHi;
                    end
                end
                StSendHi: state_q <= StWaitHi;
                StWaitHi: begin
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= StWaitA;
                    end
                end
                default: state_q <= StWaitA;
            endcase
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_ops      = ops_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_op_err   = op_err_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Randomized bench for alu_uart_ctrl with a behavioural ALU and transaction model.
module tb_alu_uart_ctrl;
    import alu_ctrl_pkg::*;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OPS  = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NB_DATA-1:0] rx_data = '0;
    logic               rx_done = 1'b0;
    logic               tx_done = 1'b0;
    logic [NB_DATA:0]   alu_res;
    logic [NB_DATA-1:0] data_a, data_b, tx_data;
    logic [NB_OPS-1:0]  ops;
    logic               tx_start, busy, op_err, overrun;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model of what the sequencer should be holding.
    logic [7:0] exp_a = '0;
    logic [7:0] exp_b = '0;
    logic [5:0] exp_ops = '0;
    logic       exp_ovr = 1'b0;
    logic [5:0] op_tab [0:7];

    always #5 clk = ~clk;

    // Behavioural ALU sitting beside the controller.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            OpAdd:   return {1'b0, a} + {1'b0, b};
            OpSub:   return {1'b0, a - b};
            OpAnd:   return {1'b0, a & b};
            OpOr:    return {1'b0, a | b};
            OpXor:   return {1'b0, a ^ b};
            OpNor:   return {1'b0, ~(a | b)};
            OpSra:   return {1'b0, a[7], a[7:1]};
            OpSrl:   return {2'b00, a[7:1]};
            default: return 9'h000;
        endcase
    endfunction

    assign alu_res = alu_f(data_a, data_b, ops);

    alu_uart_ctrl #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_done  (tx_done),
        .i_alu_res  (alu_res),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_ops      (ops),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_op_err   (op_err),
        .o_overrun  (overrun)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".a"}, 16'(data_a), 16'(exp_a));
        check({tag, ".b"}, 16'(data_b), 16'(exp_b));
        check({tag, ".ops"}, 16'(ops), 16'(exp_ops));
        check({tag, ".ovr"}, 16'(overrun), 16'(exp_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a"}, 16'(data_a), 16'h0);
        check({tag, ".b"}, 16'(data_b), 16'h0);
        check({tag, ".ops"}, 16'(ops), 16'h0);
        check({tag, ".txd"}, 16'(tx_data), 16'h0);
        check({tag, ".start"}, 16'(tx_start), 16'h0);
        check({tag, ".busy"}, 16'(busy), 16'h0);
        check({tag, ".err"}, 16'(op_err), 16'h0);
        check({tag, ".ovr"}, 16'(overrun), 16'h0);
    endtask

    // Called and returns on a falling edge; the byte is seen on the next rising edge.
    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = $urandom_range(0, 255);
    endtask

    // Wait gap (>=1) cycles in a WAIT_* state, then finish the current TX byte.
    task automatic tx_wait_done(input logic [7:0] held, input bit ovr_hit, input string tag);
        int gap;
        gap = $urandom_range(1, 4);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check({tag, ".idle_start"}, 16'(tx_start), 16'h0);
            check({tag, ".held"}, 16'(tx_data), 16'(held));
        end
        tx_done = 1'b1;
        if (ovr_hit) begin
            rx_data = $urandom_range(0, 255);
            rx_done = 1'b1;
        end
        @(negedge clk);
        tx_done = 1'b0;
        rx_done = 1'b0;
        if (ovr_hit) exp_ovr = 1'b1;
    endtask

    // One full transaction from the UART's point of view.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input bit ovr_hit);
        logic [8:0] res;
        rx_byte(a);
        exp_a = a;
        check("rx_a", 16'(data_a), 16'(exp_a));
        rx_byte(b);
        exp_b = b;
        check("rx_b", 16'(data_b), 16'(exp_b));
        rx_byte(opb);
        if (opb[7:6] != 2'b00) begin
            check("op_err", 16'(op_err), 16'h1);
            check("bad_busy", 16'(busy), 16'h0);
            check_regs("bad_op");
            @(negedge clk);
            check("op_err_width", 16'(op_err), 16'h0);
            check("bad_nostart", 16'(tx_start), 16'h0);
            return;
        end
        exp_ops = opb[5:0];
        res = alu_f(exp_a, exp_b, exp_ops);
        check("exec_ops", 16'(ops), 16'(exp_ops));
        check("exec_busy", 16'(busy), 16'h1);
        check("exec_nostart", 16'(tx_start), 16'h0);
        @(negedge clk);
        check("lo_start", 16'(tx_start), 16'h1);
        check("lo_data", 16'(tx_data), 16'(res[7:0]));
        tx_wait_done(res[7:0], ovr_hit, "wait_lo");
        check("hi_start", 16'(tx_start), 16'h1);
        check("hi_data", 16'(tx_data), 16'({7'b0, res[8]}));
        check("hi_busy", 16'(busy), 16'h1);
        check_regs("hi");
        tx_wait_done({7'b0, res[8]}, 1'b0, "wait_hi");
        check("done_busy", 16'(busy), 16'h0);
        check("done_nostart", 16'(tx_start), 16'h0);
    endtask

    initial begin
        op_tab[0] = OpAdd; op_tab[1] = OpSub; op_tab[2] = OpAnd; op_tab[3] = OpOr;
        op_tab[4] = OpXor; op_tab[5] = OpSra; op_tab[6] = OpSrl; op_tab[7] = OpNor;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(8'h05, 8'h03, 8'h20, 1'b0);
        do_op(8'hFF, 8'h01, 8'h20, 1'b0);
        do_op(8'h03, 8'h05, 8'h22, 1'b0);
        do_op(8'h80, 8'h00, 8'h03, 1'b0);
        do_op(8'h01, 8'h02, 8'hC0, 1'b0);
        do_op(8'h07, 8'h09, 8'h20, 1'b1);
        check("ovr_sticky", 16'(overrun), 16'h1);

        // Reset while waiting for the low byte to go out.
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'h20);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        exp_a = '0; exp_b = '0; exp_ops = '0; exp_ovr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_nostart", 16'(tx_start), 16'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h0A, 8'h0B, 8'h24, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] a, b, opb;
            int sel;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            if (sel < 8) opb = {2'b00, op_tab[sel]};
            else if (sel == 8) opb = {2'b00, 6'($urandom_range(0, 63))};
            else opb = {2'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
            do_op(a, b, opb, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
